jk_bank_ctrl: RTL

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

---
 rtl/jk_bank_pkg.sv | 14 +
 rtl/jk_cell.sv | 29 ++
 rtl/jk_bank_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared opcode and FSM state encodings for the JK register-bank controller.
package jk_bank_pkg;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_COUNT  = 2'd2;
  localparam logic [1:0] OP_INVERT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low clear.
// jk: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  // NOTE: state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK cells: load, clear, invert and
// multi-step count, all realised purely through per-bit j/k drive.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_cnt;
  logic             r_wrap;

  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_data  <= '0;
      r_cnt   <= 4'd0;
      r_wrap  <= 1'b0;
    end else begin
      // Only the all-ones value rolls over on an increment step.
      r_wrap <= (r_state == ST_STEP) && (&w_q);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_cnt  <= cmd_len;
            if (cmd_op == OP_COUNT) begin
              r_state <= (cmd_len == 4'd0) ? ST_DONE : ST_STEP;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: r_state <= ST_DONE;
        ST_STEP: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ripple toggle-enable of a binary incrementer: bit i toggles when all
  // lower bits are one.
  always_comb begin
    logic v_run;
    v_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = v_run;
      v_run      = v_run & w_q[i];
    end
  end

  // NOTE: defaults first so every path assigns j/k and no latch is inferred.
  always_comb begin
    w_j = '0;
    w_k = '0;
    case (r_state)
      ST_EXEC: begin
        case (r_op)
          OP_LOAD: begin
            w_j = r_data;
            w_k = ~r_data;
          end
          OP_CLEAR: w_k = '1;
          OP_INVERT: begin
            w_j = '1;
            w_k = '1;
          end
          default: ;
        endcase
      end
      ST_STEP: begin
        w_j = w_carry;
        w_k = w_carry;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .clr_n (clr_n),
      .j     (w_j[g]),
      .k     (w_k[g]),
      .q     (w_q[g])
    );
  end

  assign q         = w_q;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign wrap      = r_wrap;

endmodule
